temp_history_arbiter: RTL and testbench

//  Owns the single-port temperature-history BRAM and shares it between two requesters: a periodic

---
 rtl/temp_log_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 32 +++
 rtl/temp_history_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_temp_history_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_log_pkg.sv
// Shared types for the temperature history logger: arbiter FSM states,
// default sample width and the default playback index type.
package temp_log_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef logic [ADDR_W_DEF-1:0] sample_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAPT,
        RD_ERR
    } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample interval timer: counts 0..SAMPLE_DIV-1 and pulses o_tick on the terminal count.
// Ports: clk, rst_n (async, active-low), i_restart (sync restart to 0), o_tick (1-cycle pulse).
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int            CW   = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    // A restart wins over a coincident terminal count, so that tick is lost.
    assign o_tick = w_last && !i_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/temp_history_arbiter.sv
// Owns the single-port history BRAM: logs one sample per tick into a circular
// buffer and serves playback reads of the Nth-newest sample, writes first.
// Ports: clk, rst_n; sample_data/sample_valid (logger); clear (empty history);
//   rd_req/rd_idx in, rd_ack/rd_valid/rd_data/rd_err out (playback);
//   count/full (fill status); bram_en/we/addr/din out, bram_dout in (BRAM).
module temp_history_arbiter
    import temp_log_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SAMPLE_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam int            DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_pend;
    logic [DATA_W-1:0]   r_pend_data;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_rd_err;
    logic                r_capt;
    logic                r_bram_en;
    logic                r_bram_we;
    logic [ADDR_W-1:0]   r_bram_addr;
    logic [DATA_W-1:0]   r_bram_din;

    logic                w_tick;
    logic                w_new;
    logic                w_wr_go;
    logic                w_idx_bad;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [DATA_W-1:0]   w_wr_data;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (clear),
        .o_tick    (w_tick)
    );

    // A tick in this very cycle counts as pending, so a read raised on the
    // tick cycle still yields to the write and then sees the new sample.
    assign w_new     = w_tick && sample_valid;
    assign w_wr_go   = r_pend || w_new;
    assign w_wr_data = w_new ? sample_data : r_pend_data;
    assign w_idx_bad = ({1'b0, rd_idx} >= r_count);
    assign w_rd_addr = r_wr_ptr - ADDR_W'(1) - rd_idx;
    assign w_accept  = (r_state == IDLE) && !w_wr_go && rd_req && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
            r_capt      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            // Outputs are set on entry to the state that owns them.
            r_bram_en  <= 1'b0;
            r_bram_we  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_capt     <= 1'b0;

            if (w_new) begin
                r_pend      <= 1'b1;
                r_pend_data <= sample_data;
            end

            if (clear) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_pend   <= 1'b0;
                if (r_state == RD_CAPT) begin
                    r_rd_data <= bram_dout;
                end
                // An in-flight read is closed out with an error.
                if (r_state == RD_ISSUE || r_state == RD_CAPT) begin
                    r_state    <= RD_ERR;
                    r_rd_valid <= 1'b1;
                    r_rd_err   <= 1'b1;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_wr_go) begin
                            r_state     <= WR;
                            r_bram_en   <= 1'b1;
                            r_bram_we   <= 1'b1;
                            r_bram_addr <= r_wr_ptr;
                            r_bram_din  <= w_wr_data;
                        end else if (rd_req) begin
                            if (w_idx_bad) begin
                                r_state    <= RD_ERR;
                                r_rd_valid <= 1'b1;
                                r_rd_err   <= 1'b1;
                            end else begin
                                r_state     <= RD_ISSUE;
                                r_bram_en   <= 1'b1;
                                r_bram_addr <= w_rd_addr;
                            end
                        end
                    end
                    WR: begin
                        r_state  <= IDLE;
                        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + (ADDR_W + 1)'(1);
                        end
                        if (!w_new) begin
                            r_pend <= 1'b0;
                        end
                    end
                    RD_ISSUE: begin
                        r_state    <= RD_CAPT;
                        r_rd_valid <= 1'b1;
                        r_capt     <= 1'b1;
                    end
                    RD_CAPT: begin
                        r_state   <= IDLE;
                        r_rd_data <= bram_dout;
                    end
                    RD_ERR: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // BRAM data lands in the capture cycle; show it live alongside
    // rd_valid and hold the registered copy afterwards.
    assign rd_data   = r_capt ? bram_dout : r_rd_data;
    assign rd_ack    = rst_n && w_accept;
    assign rd_valid  = r_rd_valid;
    assign rd_err    = r_rd_err;
    assign count     = r_count;
    assign full      = (r_count == CNT_MAX);
    assign bram_en   = r_bram_en;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;

endmodule

// File: tb/tb_temp_history_arbiter.sv
// Directed bench for temp_history_arbiter with a behavioural BRAM and a
// read scoreboard (ADDR_W=3, SAMPLE_DIV=8).
module tb_temp_history_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       clear;
    logic       rd_req;
    logic [2:0] rd_idx;
    logic       rd_ack;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_err;
    logic [3:0] count;
    logic       full;
    logic       bram_en;
    logic       bram_we;
    logic [2:0] bram_addr;
    logic [7:0] bram_din;
    logic [7:0] bram_dout;

    logic [7:0] mem [0:7];
    logic [8:0] sb [$];
    int         n_pass;
    int         n_total;
    logic [2:0] exp_ptr;
    int         exp_cnt;

    temp_history_arbiter #(
        .ADDR_W     (3),
        .DATA_W     (8),
        .SAMPLE_DIV (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .clear        (clear),
        .rd_req       (rd_req),
        .rd_idx       (rd_idx),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .count        (count),
        .full         (full),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ack"},   32'(rd_ack),    0);
        chk({tag, ".valid"}, 32'(rd_valid),  0);
        chk({tag, ".data"},  32'(rd_data),   0);
        chk({tag, ".err"},   32'(rd_err),    0);
        chk({tag, ".count"}, 32'(count),     0);
        chk({tag, ".full"},  32'(full),      0);
        chk({tag, ".en"},    32'(bram_en),   0);
        chk({tag, ".we"},    32'(bram_we),   0);
        chk({tag, ".addr"},  32'(bram_addr), 0);
        chk({tag, ".din"},   32'(bram_din),  0);
    endtask

    // Log one sample; lat >= 0 also checks cycles until the WR cycle.
    task automatic log_s(input logic [7:0] d, input int lat);
        int k;
        k = 0;
        sample_data  = d;
        sample_valid = 1'b1;
        while (!bram_we && k < 20) begin
            step();
            k++;
        end
        chk("wr_seen", 32'(bram_we), 1);
        chk("wr_din",  32'(bram_din), 32'(d));
        chk("wr_addr", 32'(bram_addr), 32'(exp_ptr));
        if (lat >= 0) chk("wr_lat", 32'(k), 32'(lat));
        sample_valid = 1'b0;
        exp_ptr = exp_ptr + 3'd1;
        if (exp_cnt < 8) exp_cnt++;
        step();
        chk("wr_count", 32'(count), 32'(exp_cnt));
    endtask

    task automatic rd(input int idx, input bit e, input logic [7:0] d);
        int         k;
        logic [8:0] x;
        sb.push_back({e, d});
        rd_idx = idx[2:0];
        rd_req = 1'b1;
        #1;
        k = 0;
        while (!rd_ack && k < 10) begin
            step();
            k++;
        end
        chk("rd_ack", 32'(rd_ack), 1);
        step();
        rd_req = 1'b0;
        if (e) chk("err_no_en", 32'(bram_en), 0);
        k = 1;
        while (!rd_valid && k < 6) begin
            step();
            k++;
        end
        chk("rd_valid", 32'(rd_valid), 1);
        chk("rd_lat", 32'(k), e ? 32'd1 : 32'd2);
        x = sb.pop_front();
        chk("rd_err", 32'(rd_err), 32'(x[8]));
        if (!x[8]) begin
            chk("rd_data", 32'(rd_data), 32'(x[7:0]));
            step();
            chk("rd_hold", 32'(rd_data), 32'(x[7:0]));
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear   = 1'b0;
        exp_ptr = 3'd0;
        exp_cnt = 0;
        chk("clr_count", 32'(count), 0);
        chk("clr_full",  32'(full), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int         we_seen;
        logic [8:0] x;
        n_pass       = 0;
        n_total      = 0;
        exp_ptr      = 3'd0;
        exp_cnt      = 0;
        rst_n        = 1'b1;
        sample_data  = 8'd0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        rd_req       = 1'b0;
        rd_idx       = 3'd0;
        #1 rst_n = 1'b0;
        #3 chk_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) log_s(8'(70 + i), -1);
        chk("cnt5", 32'(count), 5);
        rd(0, 1'b0, 8'd74);
        rd(4, 1'b0, 8'd70);
        rd(2, 1'b0, 8'd72);

        do_clear();
        log_s(8'd60, 8);
        for (int i = 1; i < 10; i++) log_s(8'(60 + i), -1);
        chk("full", 32'(full), 1);
        chk("cnt_sat", 32'(count), 8);
        rd(7, 1'b0, 8'd62);
        rd(0, 1'b0, 8'd69);

        do_clear();
        log_s(8'd80, -1);
        log_s(8'd81, -1);
        log_s(8'd82, -1);
        rd(3, 1'b1, 8'd0);
        rd(2, 1'b0, 8'd80);

        // Read raised on the tick cycle: write goes first.
        log_s(8'd83, -1);
        repeat (6) step();
        sample_data  = 8'd90;
        sample_valid = 1'b1;
        rd_idx       = 3'd0;
        rd_req       = 1'b1;
        #1;
        chk("col_noack0", 32'(rd_ack), 0);
        step();
        sample_valid = 1'b0;
        chk("col_we",     32'(bram_we), 1);
        chk("col_din",    32'(bram_din), 90);
        chk("col_noack1", 32'(rd_ack), 0);
        step();
        chk("col_ack", 32'(rd_ack), 1);
        sb.push_back({1'b0, 8'd90});
        step();
        rd_req = 1'b0;
        step();
        x = sb.pop_front();
        chk("col_valid", 32'(rd_valid), 1);
        chk("col_data",  32'(rd_data), 32'(x[7:0]));
        chk("col_count", 32'(count), 5);

        // Ticks without a valid sample log nothing.
        sample_data = 8'd55;
        we_seen     = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bram_we) we_seen++;
        end
        chk("novalid_we",  32'(we_seen), 0);
        chk("novalid_cnt", 32'(count), 5);

        // Clear while the read is in RD_ISSUE.
        rd_idx = 3'd0;
        rd_req = 1'b1;
        #1;
        chk("abort_ack", 32'(rd_ack), 1);
        sb.push_back({1'b1, 8'd90});
        step();
        rd_req = 1'b0;
        chk("abort_issue", 32'(bram_en), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        x = sb.pop_front();
        chk("abort_valid", 32'(rd_valid), 1);
        chk("abort_err",   32'(rd_err), 32'(x[8]));
        chk("abort_hold",  32'(rd_data), 32'(x[7:0]));
        chk("abort_cnt",   32'(count), 0);
        exp_ptr = 3'd0;
        exp_cnt = 0;
        step();
        rd(0, 1'b1, 8'd0);

        // Asynchronous reset in the middle of a write.
        sample_data  = 8'd99;
        sample_valid = 1'b1;
        for (int i = 0; i < 20 && !bram_we; i++) step();
        chk("pre_rst_we", 32'(bram_we), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid_wr");
        sample_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
